uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter (8N1, `din`/`trigger`/`busy` interface) between `NUM_REQ` byte producers. It accepts one byte at a time over a valid/ready handshake and launches it with a one-cycle trigger. It holds the byte stable for the whole frame and releases the transmitter only after its busy flag has risen and fallen. It sits between the system's byte sources and the transmitter, and owns the transmitter's `din` and `trigger` pins exclusively.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `ID_W`, 2: width of `grant_id`; 2**ID_W >= NUM_REQ.
- `TIMEOUT`, 32'd4096: max cycles in WAIT_BUSY before abort; must exceed 2×(transmitter clocks-per-bit + 2).
- `clk` in 1: clock, rising edge.
- `rst_` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: bit i = requester i has a byte.
- `req_data` in 8*NUM_REQ: byte of requester i at [8i+7:8i].
- `req_ready` out NUM_REQ: one-hot acceptance strobe.
- `tx_din` out 8: byte to transmitter.
- `tx_trigger` out 1: one-cycle start pulse to transmitter.
- `tx_busy` in 1: transmitter busy flag.
- `grant_id` out ID_W: index of current/last granted requester.
- `active` out 1: high from ISSUE through WAIT_DONE.
- `done` out 1: one-cycle pulse, frame completed.
- `timeout_err` out 1: one-cycle pulse, WAIT_BUSY timed out.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If any `req_valid` and `tx_busy`=0, select winner w by round-robin.
  - Search starts at `last_grant`+1 mod NUM_REQ and proceeds upward with wrap.
  - `req_ready[w]`=1 combinationally this cycle only. On the edge: `tx_din`<=data of w, `grant_id`<=w, `last_grant`<=w, go to ISSUE.
  - `tx_busy`=1 in IDLE blocks all grants, and `req_ready` stays 0.
- ISSUE: `tx_trigger`=1 for exactly this cycle. `tx_busy` is ignored. Clear the timeout counter and go to WAIT_BUSY.
- WAIT_BUSY:
  - Count cycles. On `tx_busy`=1, go to WAIT_DONE.
  - If the count reaches TIMEOUT-1 with `tx_busy` still 0, pulse `timeout_err` and go to IDLE. The byte is dropped and `last_grant` keeps w.
- WAIT_DONE: on `tx_busy`=0, pulse `done` and go to IDLE.
- `tx_din` holds the captured byte unchanged from the ISSUE cycle until the next grant. The transmitter samples `din` at the end of the start bit.
- Requesters must hold `req_valid` and their data stable until they see `req_ready`. Dropping `req_valid` before a grant is allowed and loses nothing.
- Counter width: 32 bits, no wrap; saturation is impossible because exit occurs at TIMEOUT-1.
- Reset, asynchronous, also mid-frame:
  - Return to IDLE with `last_grant`=NUM_REQ-1, so requester 0 wins first.
  - Outputs: `tx_din`=0, `tx_trigger`=0, `req_ready`=0, `grant_id`=0, `active`=0, `done`=0, `timeout_err`=0.

## Timing
- All outputs are registered except `req_ready`, which is decoded from the registered state and `req_valid`.
- Grant in cycle N: `tx_trigger` and `active` are high in cycle N+1, and WAIT_BUSY starts at cycle N+2.
- `tx_busy` rising in cycle M: state is WAIT_DONE at M+1. `tx_busy` falling in cycle K: `done`=1 and state is IDLE at K+1, with `active`=0 at K+1.
- Back-to-back operation: a new grant is possible in the same IDLE cycle that `done` is high. The minimum per-byte overhead is 2 arbiter cycles plus the transmitter frame.
- Simultaneous `done`/IDLE cycle and new requests: arbitration uses the updated `last_grant`.
- `timeout_err` and `done` are never high in the same cycle. `req_ready` is never asserted outside IDLE.

## Test plan
- **Single requester.** Requester 0 valid with 8'hA5, TIMEOUT=64, behavioral Tx (busy rises 5 cycles after trigger, frame 40 cycles).
  - `req_ready`=4'b0001 for one cycle, `tx_trigger` one cycle later, `tx_din`=8'hA5 held throughout.
  - `done` pulses one cycle after busy falls, and `grant_id`=0.
- **Round-robin with two requesters.** Requesters 1 and 3 continuously valid: grant order is 1,3,1,3 and each `done` is followed by the next `req_ready` in the same cycle.
- **Fairness with all four.** All four valid for 8 frames: grant order is 0,1,2,3,0,1,2,3 and no requester is granted twice in a row.
- **Timeout.** Tx model never raises busy, TIMEOUT=16: `timeout_err` pulses exactly 16 cycles after WAIT_BUSY entry, the state returns to IDLE, and the next grant goes to `last_grant`+1.
- **Reset mid-frame.** Assert `rst_`=0 during WAIT_DONE:
  - All outputs go to 0 immediately without waiting for a clock edge.
  - After release with requesters 2 and 0 valid, requester 0 is granted first.
- **Busy at idle.** `tx_busy` is forced 1 while requester 2 is valid: `req_ready` stays 0. When `tx_busy` is released, the grant occurs in the next IDLE cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one 8N1 transmitter among NUM_REQ byte producers
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2,
  parameter logic [31:0] TIMEOUT = 32'd4096
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_din,
  output logic                 tx_trigger,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active,
  output logic                 done,
  output logic                 timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state;
  logic [ID_W-1:0] last_grant, win, idx;
  logic [31:0] cnt;
  logic found, take;
  always_comb begin
    win = last_grant;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  assign take = state == IDLE && !tx_busy && found;
  assign req_ready = take ? NUM_REQ'(1) << win : '0;
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cnt <= '0;
      tx_din <= '0;
      tx_trigger <= 1'b0;
      grant_id <= '0;
      active <= 1'b0;
      done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_trigger <= 1'b0;
      done <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (take) begin
          tx_din <= req_data[8*win +: 8];
          grant_id <= win;
          last_grant <= win;
          tx_trigger <= 1'b1;
          active <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          cnt <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (tx_busy) state <= WAIT_DONE;
          else if (cnt == TIMEOUT - 1) begin
            timeout_err <= 1'b1;
            active <= 1'b0;
            state <= IDLE;
          end else cnt <= cnt + 1;
        WAIT_DONE: if (!tx_busy) begin
          done <= 1'b1;
          active <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench with behavioural transmitter and round-robin model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int IW = 2;
  localparam logic [31:0] TO = 32'd16;
  logic clk = 0, rst_ = 1, tx_busy = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] tx_din;
  logic tx_trigger, active, done, timeout_err;
  logic [IW-1:0] grant_id;
  uart_tx_arbiter #(.NUM_REQ(N), .ID_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_(rst_), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_din(tx_din), .tx_trigger(tx_trigger), .tx_busy(tx_busy), .grant_id(grant_id),
    .active(active), .done(done), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [7:0] data;
    logic to;
    logic b2b;
  } exp_t;
  exp_t sb[$];
  exp_t cur;
  logic [7:0] rq[N][$];
  int errors = 0, checks = 0, cyc = 0;
  int t_rdy = 0, t_trig = 0, t_fin = 0, t_fall = 0, model_last = N - 1;
  int lat_cfg = 5, frame_cfg = 40, g_id = 0, tl, tf;
  bit tx_never = 0, g_pend = 0, prev_busy = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    if (g_pend) begin
      void'(rq[g_id].pop_front());
      g_pend = 0;
    end
    for (int i = 0; i < N; i++) begin
      req_valid[i] = rq[i].size() != 0;
      req_data[8*i +: 8] = rq[i].size() != 0 ? rq[i][0] : 8'h00;
    end
  end
  always @(negedge clk) begin
    if (tx_trigger && !tx_never) begin
      tl = lat_cfg != 0 ? lat_cfg : int'($urandom_range(1, 8));
      tf = frame_cfg != 0 ? frame_cfg : int'($urandom_range(1, 40));
      repeat (tl) @(posedge clk);
      #1 tx_busy = 1;
      repeat (tf) @(posedge clk);
      #1 tx_busy = 0;
    end
  end
  always @(negedge clk) begin
    if (rst_) begin
      if (done || timeout_err) begin
        chk("done_err_exclusive", 32'(done & timeout_err), 0);
        if (sb.size() == 0) chk("spurious_end", 1, 0);
        else begin
          chk("outcome_timeout", 32'(timeout_err), 32'(sb[0].to));
          chk("end_latency", cyc, timeout_err ? t_trig + int'(TO) + 1 : t_fall + 1);
          void'(sb.pop_front());
          t_fin = cyc;
        end
      end
      if (req_ready != 0) begin
        if (sb.size() == 0) chk("spurious_grant", 32'(req_ready), 0);
        else begin
          cur = sb[0];
          chk("grant_onehot", 32'(req_ready), 1 << cur.id);
          if (cur.b2b) chk("back_to_back_grant", cyc, t_fin);
          t_rdy = cyc;
          g_id = int'(cur.id);
          g_pend = 1;
        end
      end
      if (tx_trigger) begin
        chk("trigger_latency", cyc, t_rdy + 1);
        chk("trigger_din", 32'(tx_din), 32'(cur.data));
        chk("trigger_grant_id", 32'(grant_id), 32'(cur.id));
        t_trig = cyc;
      end
      if (active) begin
        chk("din_hold", 32'(tx_din), 32'(cur.data));
        chk("ready_outside_idle", 32'(req_ready), 0);
      end
    end
    if (prev_busy && !tx_busy) t_fall = cyc;
    prev_busy = tx_busy;
  end
  task automatic plan(input bit to);
    int pos[N];
    bit any, first;
    exp_t e;
    first = 1;
    for (int i = 0; i < N; i++) pos[i] = 0;
    do begin
      any = 0;
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (model_last + k) % N;
        if (!any && pos[i] < rq[i].size()) begin
          e.id = IW'(i);
          e.data = rq[i][pos[i]];
          e.to = to;
          e.b2b = !first && !to;
          sb.push_back(e);
          pos[i]++;
          model_last = i;
          first = 0;
          any = 1;
        end
      end
    end while (any);
  endtask
  task automatic load(input logic [N-1:0] mask, input int n, input bit to);
    for (int i = 0; i < N; i++) if (mask[i]) repeat (n) rq[i].push_back(8'($urandom));
    plan(to);
  endtask
  task automatic drain(input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk("drain_timeout", sb.size(), 0);
    if (sb.size() != 0) begin
      sb.delete();
      for (int i = 0; i < N; i++) rq[i].delete();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_din"}, 32'(tx_din), 0);
    chk({tag, "_trigger"}, 32'(tx_trigger), 0);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_grant_id"}, 32'(grant_id), 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
  endtask
  initial begin
    int c;
    #2 rst_ = 0;
    #1 chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst_ = 1;
    @(posedge clk);
    #1 rq[0].push_back(8'hA5);
    plan(0);
    drain(200);
    chk("single_grant_id", 32'(grant_id), 0);
    chk("single_din", 32'(tx_din), 32'h A5);
    lat_cfg = 0;
    frame_cfg = 0;
    load(4'b1010, 2, 0);
    drain(400);
    load(4'b1111, 2, 0);
    drain(800);
    repeat (6) begin
      load(4'($urandom_range(1, 15)), int'($urandom_range(1, 3)), 0);
      drain(1000);
    end
    tx_never = 1;
    load(4'(1 << $urandom_range(0, 3)), 1, 1);
    drain(100);
    tx_never = 0;
    load(4'b1111, 1, 0);
    drain(400);
    tx_busy = 1;
    load(4'b0100, 1, 0);
    repeat (8) begin
      @(negedge clk);
      chk("busy_blocks_grant", 32'(req_ready), 0);
    end
    @(posedge clk);
    #1 tx_busy = 0;
    #1 chk("busy_release_grant", 32'(req_ready), 32'b0100);
    drain(200);
    lat_cfg = 5;
    frame_cfg = 40;
    load(4'b0010, 1, 0);
    c = 0;
    while (!(active && tx_busy) && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("reach_wait_done", 32'(active && tx_busy), 1);
    @(negedge clk);
    #2 rst_ = 0;
    #1 chk_reset_outputs("midframe_reset");
    sb.delete();
    g_pend = 0;
    model_last = N - 1;
    c = 0;
    while (tx_busy && c < 100) begin
      @(posedge clk);
      c++;
    end
    @(posedge clk);
    #1 load(4'b0101, 1, 0);
    @(posedge clk);
    #1 rst_ = 1;
    drain(400);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
